l1_cache_ctrl_fsm: RTL and testbench
====================================

// Module: l1_cache_ctrl_fsm
// PURPOSE
//  Parametrised L1 cache miss-handling FSM. Sits between the core request port, the tag/data arrays
//  and the bus transform. Sequences lookup, multi-beat dirty-victim writeback, multi-beat line refill
//  and commit. Supports N ways and B beats per line, with a defined abort policy when core_en drops.
// PARAMETERS
//  BEATS     4   bus beats per cache line (power of 2, >=2)
//  NUM_WAYS  2   associativity (power of 2, >=1)
//  PERF_W    32  width of performance counters
//  (local) BEAT_W = clog2(BEATS), WAY_W = max(1, clog2(NUM_WAYS))
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       synchronous active-low reset
//  core_en        in   1       cache enable; low requests abort
//  core_req_vld   in   1       core request valid
//  core_req_rd    in   1       1=read, 0=write
//  core_req_rdy   out  1       request accepted this cycle; asserted only in IDLE
//  tag_hit        in   1       lookup hit; sampled in LOOKUP
//  hit_way        in   WAY_W   hitting way; sampled in LOOKUP
//  victim_way     in   WAY_W   replacement way; sampled in LOOKUP
//  victim_dirty   in   1       victim valid && dirty; sampled in LOOKUP
//  bus_wr_req     out  1       writeback burst request, held through WRITEBACK
//  bus_wr_ack     in   1       one writeback beat accepted
//  bus_rd_req     out  1       refill burst request, held through REFILL
//  bus_rd_vld     in   1       one refill beat returned
//  beat_idx       out  BEAT_W  current beat of the active burst
//  sel_way        out  WAY_W   latched way for the access (hit_way or victim_way)
//  fill_we        out  1       write refill beat beat_idx into sel_way (= bus_rd_vld in REFILL)
//  tag_we         out  1       COMMIT: write tag, set valid, dirty=!req_rd
//  data_we        out  1       COMMIT: write-hit/write-miss store data into sel_way
//  lru_upd        out  1       update replacement state for sel_way (one pulse per completed access)
//  done           out  1       one-cycle completion pulse to core
//  fsm_state      out  3       current state
//  fsm_state_d1   out  3       fsm_state delayed one cycle
//  perf_hit_cnt   out  PERF_W  hits (see CONFIGURATION)
//  perf_miss_cnt  out  PERF_W  misses
//  perf_wb_cnt    out  PERF_W  writebacks
// BEHAVIOUR
//  States: IDLE=0, LOOKUP=1, WRITEBACK=2, REFILL=3, COMMIT=4. Codes 5..7 -> IDLE next cycle.
//  Reset (rst_n low at posedge): state/state_d1=IDLE. beat_idx, sel_way, abort flag, counters = 0.
//   All strobes (req_rdy excepted) = 0. Reset mid-burst abandons the burst immediately.
//  IDLE: core_req_rdy = core_en. On vld&&rdy, latch req_rd -> LOOKUP. vld with core_en=0 is not accepted.
//  LOOKUP (1 cycle): latch sel_way = tag_hit ? hit_way : victim_way.
//   Read hit -> done+lru_upd this cycle, -> IDLE. Write hit -> COMMIT.
//   Miss && victim_dirty -> WRITEBACK. Miss && !victim_dirty -> REFILL.
//  WRITEBACK: bus_wr_req=1. beat_idx++ on each bus_wr_ack. Ack at beat BEATS-1 -> beat_idx=0, -> REFILL.
//  REFILL: bus_rd_req=1. fill_we=bus_rd_vld. beat_idx++ per vld. Last beat -> beat_idx=0, -> COMMIT.
//   bus_wr_ack outside WRITEBACK and bus_rd_vld outside REFILL are ignored.
//  COMMIT (1 cycle): tag_we=1 on miss path only. data_we=!req_rd. lru_upd=1, done=1 -> IDLE.
//  Latency (no stalls): read hit 2 cycles (accept->done); write hit 3; clean miss 3+BEATS;
//   dirty miss 3+2*BEATS.
//  Abort: core_en=0 in LOOKUP or COMMIT -> IDLE next cycle, no done/tag_we/data_we/lru_upd.
//   core_en=0 during WRITEBACK/REFILL sets a sticky abort flag. The current burst completes
//   (bus protocol is never truncated). WRITEBACK then moves on to REFILL only if not aborted.
//   Burst end with abort set -> IDLE, no COMMIT, no done; abort flag clears in IDLE.
//   Abort while the last beat is in flight behaves identically.
//  fsm_state_d1 follows fsm_state by exactly one cycle, including through reset.
// CONFIGURATION
//  L1_CACHE_FSM_PERF_CNT_EN defined: perf_* increment in LOOKUP on hit/miss and on WRITEBACK
//   entry; they saturate at all-ones. They also count requests that are later aborted.
//  Undefined: perf_* are tied to 0; ports are retained, so no logic is generated.
// STRUCTURE
//  Define.v: state encodings (`L1C_ST_IDLE..`L1C_ST_COMMIT) and the 3-bit state width.
//  Sub-module l1_beat_counter: BEAT_W up-counter with inc, clr and last output. One instance,
//   shared by WRITEBACK and REFILL.
// TESTING
//  Read hit, BEATS=4: vld+rd, tag_hit=1, hit_way=1 -> done at cycle 2, sel_way=1, no bus_*_req.
//  Clean read miss: victim_way=0, 4 rd_vld one per cycle -> 4 fill_we with beat_idx 0..3, then
//   tag_we+done, total 7 cycles.
//  Dirty write miss, with wr_ack stalled 2 cycles between beats -> bus_wr_req held, beat_idx only
//   advances on ack, then refill, then COMMIT with data_we=1, tag_we=1. perf_wb_cnt=1.
//  Abort: core_en=0 after 2nd refill beat -> remaining 2 beats still absorbed, then IDLE,
//   no done/tag_we. Next request is accepted normally.
//  Sync reset mid-WRITEBACK (beat 2) -> next cycle state=IDLE, beat_idx=0, bus_wr_req=0.
//  PERF_W=4 with macro defined: 20 read hits -> perf_hit_cnt=15 (saturated). Macro undefined -> 0.

Source files
------------

// File: rtl/l1_cache_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// l1_cache_ctrl_fsm_pkg
//  Shared definitions for the L1 cache miss-handling controller:
//   - STATE_W      : width of the exported state code
//   - l1c_state_e  : state encodings (IDLE=0 .. COMMIT=4); codes 5..7 are
//                    illegal and recover to IDLE
//   - way_width()  : way-index width, at least one bit even for a
//                    direct-mapped cache
// -----------------------------------------------------------------------------
package l1_cache_ctrl_fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_COMMIT    = 3'd4
    } l1c_state_e;

    function automatic int way_width(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/l1_cache_ctrl_fsm_beat_counter.sv
// -----------------------------------------------------------------------------
// l1_cache_ctrl_fsm_beat_counter
//  Beat index for the single active bus burst (writeback or refill share it).
//  Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (count -> 0)
//   i_clr    force count to 0 (has priority over i_inc)
//   i_inc    one beat completed; wraps to 0 after the last beat
//   o_cnt    current beat index
//   o_last   count is on the final beat of the line
// -----------------------------------------------------------------------------
module l1_cache_ctrl_fsm_beat_counter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = $clog2(BEATS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [BEAT_W-1:0] o_cnt,
    output logic              o_last
);

    localparam logic [BEAT_W-1:0] CNT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] CNT_LAST = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == CNT_LAST);

    // Beat counter: clear wins, final beat returns to 0 for the next burst.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= {BEAT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {BEAT_W{1'b0}};
        end else if (i_inc) begin
            r_cnt <= o_last ? {BEAT_W{1'b0}} : (r_cnt + CNT_ONE);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/l1_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// l1_cache_ctrl_fsm
//  L1 cache miss-handling FSM: lookup, multi-beat dirty-victim writeback,
//  multi-beat refill and commit, with an abort policy driven by i_core_en.
//  Optional feature macro: L1_CACHE_FSM_PERF_CNT_EN (saturating perf counters;
//  when undefined the perf outputs are tied to zero).
//  Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_core_en                 cache enable, low requests an abort
//   i_core_req_vld/_rd        core request (rd=1 read, 0 write)
//   o_core_req_rdy            request accepted (IDLE only)
//   i_tag_hit, i_hit_way      lookup result, sampled in LOOKUP
//   i_victim_way/_dirty       replacement candidate, sampled in LOOKUP
//   o_bus_wr_req/i_bus_wr_ack writeback burst request / per-beat accept
//   o_bus_rd_req/i_bus_rd_vld refill burst request / per-beat return
//   o_beat_idx                beat index of the active burst
//   o_sel_way                 way latched for this access
//   o_fill_we                 write refill beat into o_sel_way
//   o_tag_we, o_data_we       commit strobes
//   o_lru_upd, o_done         completion strobes
//   o_fsm_state(_d1)          state code and its one-cycle-delayed copy
//   o_perf_*                  hit / miss / writeback counters
// -----------------------------------------------------------------------------
module l1_cache_ctrl_fsm
    import l1_cache_ctrl_fsm_pkg::*;
#(
    parameter  int BEATS    = 4,
    parameter  int NUM_WAYS = 2,
    parameter  int PERF_W   = 32,
    localparam int BEAT_W   = $clog2(BEATS),
    localparam int WAY_W    = way_width(NUM_WAYS)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_core_en,
    input  logic               i_core_req_vld,
    input  logic               i_core_req_rd,
    output logic               o_core_req_rdy,
    input  logic               i_tag_hit,
    input  logic [WAY_W-1:0]   i_hit_way,
    input  logic [WAY_W-1:0]   i_victim_way,
    input  logic               i_victim_dirty,
    output logic               o_bus_wr_req,
    input  logic               i_bus_wr_ack,
    output logic               o_bus_rd_req,
    input  logic               i_bus_rd_vld,
    output logic [BEAT_W-1:0]  o_beat_idx,
    output logic [WAY_W-1:0]   o_sel_way,
    output logic               o_fill_we,
    output logic               o_tag_we,
    output logic               o_data_we,
    output logic               o_lru_upd,
    output logic               o_done,
    output logic [STATE_W-1:0] o_fsm_state,
    output logic [STATE_W-1:0] o_fsm_state_d1,
    output logic [PERF_W-1:0]  o_perf_hit_cnt,
    output logic [PERF_W-1:0]  o_perf_miss_cnt,
    output logic [PERF_W-1:0]  o_perf_wb_cnt
);

    l1c_state_e        r_state;
    l1c_state_e        w_state_nxt;
    logic [STATE_W-1:0] r_state_d1;
    logic              r_req_rd;
    logic              r_miss;
    logic              r_abort;
    logic [WAY_W-1:0]  r_sel_way;

    logic              w_accept;
    logic              w_abort_any;
    logic              w_cnt_inc;
    logic              w_cnt_clr;
    logic              w_cnt_last;
    logic [BEAT_W-1:0] w_beat_idx;

    assign w_accept    = (r_state == ST_IDLE) && i_core_req_vld && i_core_en;
    // An abort seen on the very cycle a burst ends counts the same as an
    // earlier one, so the live enable is folded into the sticky flag here.
    assign w_abort_any = r_abort || !i_core_en;

    assign o_fsm_state    = r_state;
    assign o_fsm_state_d1 = r_state_d1;
    assign o_beat_idx     = w_beat_idx;
    assign o_sel_way      = r_sel_way;

    l1_cache_ctrl_fsm_beat_counter #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_beat_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_cnt   (w_beat_idx),
        .o_last  (w_cnt_last)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Delayed state copy: deliberately not reset so it tracks the state code
    // by exactly one cycle even across a reset.
    always_ff @(posedge i_clk) begin
        r_state_d1 <= r_state;
    end

    // Per-request context: access type at accept, hit/miss and way at lookup.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_req_rd  <= 1'b0;
            r_miss    <= 1'b0;
            r_sel_way <= {WAY_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_req_rd <= i_core_req_rd;
            end
            if (r_state == ST_LOOKUP) begin
                r_miss    <= !i_tag_hit;
                r_sel_way <= i_tag_hit ? i_hit_way : i_victim_way;
            end
        end
    end

    // Sticky abort: set by a disable during a burst, cleared once back in IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_abort <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_abort <= 1'b0;
        end else if (((r_state == ST_WRITEBACK) || (r_state == ST_REFILL)) && !i_core_en) begin
            r_abort <= 1'b1;
        end else begin
            r_abort <= r_abort;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_nxt    = r_state;
        o_core_req_rdy = 1'b0;
        o_bus_wr_req   = 1'b0;
        o_bus_rd_req   = 1'b0;
        o_fill_we      = 1'b0;
        o_tag_we       = 1'b0;
        o_data_we      = 1'b0;
        o_lru_upd      = 1'b0;
        o_done         = 1'b0;
        w_cnt_inc      = 1'b0;
        w_cnt_clr      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                o_core_req_rdy = i_core_en;
                w_cnt_clr      = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_LOOKUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_LOOKUP: begin
                w_cnt_clr = 1'b1;
                if (!i_core_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_tag_hit) begin
                    if (r_req_rd) begin
                        o_done      = 1'b1;
                        o_lru_upd   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_COMMIT;
                    end
                end else if (i_victim_dirty) begin
                    w_state_nxt = ST_WRITEBACK;
                end else begin
                    w_state_nxt = ST_REFILL;
                end
            end

            ST_WRITEBACK: begin
                o_bus_wr_req = 1'b1;
                w_cnt_inc    = i_bus_wr_ack;
                if (i_bus_wr_ack && w_cnt_last) begin
                    w_state_nxt = w_abort_any ? ST_IDLE : ST_REFILL;
                end else begin
                    w_state_nxt = ST_WRITEBACK;
                end
            end

            ST_REFILL: begin
                o_bus_rd_req = 1'b1;
                o_fill_we    = i_bus_rd_vld;
                w_cnt_inc    = i_bus_rd_vld;
                if (i_bus_rd_vld && w_cnt_last) begin
                    w_state_nxt = w_abort_any ? ST_IDLE : ST_COMMIT;
                end else begin
                    w_state_nxt = ST_REFILL;
                end
            end

            ST_COMMIT: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
                if (i_core_en) begin
                    o_tag_we  = r_miss;
                    o_data_we = !r_req_rd;
                    o_lru_upd = 1'b1;
                    o_done    = 1'b1;
                end else begin
                    o_tag_we  = 1'b0;
                    o_data_we = 1'b0;
                    o_lru_upd = 1'b0;
                    o_done    = 1'b0;
                end
            end

            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef L1_CACHE_FSM_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] r_perf_hit;
    logic [PERF_W-1:0] r_perf_miss;
    logic [PERF_W-1:0] r_perf_wb;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : (v + PERF_ONE);
    endfunction

    // Performance counters: classified at lookup, so aborted requests count too.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_perf_hit  <= {PERF_W{1'b0}};
            r_perf_miss <= {PERF_W{1'b0}};
            r_perf_wb   <= {PERF_W{1'b0}};
        end else if (r_state == ST_LOOKUP) begin
            if (i_tag_hit) begin
                r_perf_hit <= sat_inc(r_perf_hit);
            end else begin
                r_perf_miss <= sat_inc(r_perf_miss);
            end
            if (w_state_nxt == ST_WRITEBACK) begin
                r_perf_wb <= sat_inc(r_perf_wb);
            end
        end
    end

    assign o_perf_hit_cnt  = r_perf_hit;
    assign o_perf_miss_cnt = r_perf_miss;
    assign o_perf_wb_cnt   = r_perf_wb;
`else
    assign o_perf_hit_cnt  = {PERF_W{1'b0}};
    assign o_perf_miss_cnt = {PERF_W{1'b0}};
    assign o_perf_wb_cnt   = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_l1_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_l1_cache_ctrl_fsm
//  Self-checking bench for l1_cache_ctrl_fsm (BEATS=4, NUM_WAYS=2, PERF_W=4).
//  A transaction runner drives one request, acts as the bus responder with a
//  configurable per-beat stall, and summarises what the DUT did. Expectations
//  come from a hand-derived table and from a timeline model of the request.
// -----------------------------------------------------------------------------
module tb_l1_cache_ctrl_fsm;

    localparam int BEATS    = 4;
    localparam int PERF_MAX = 15;
    localparam int S_IDLE   = 0;
    localparam int S_WB     = 2;
`ifdef L1_CACHE_FSM_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, core_en, core_req_vld, core_req_rd, core_req_rdy;
    logic       tag_hit, victim_dirty;
    logic [0:0] hit_way, victim_way, sel_way;
    logic       bus_wr_req, bus_wr_ack, bus_rd_req, bus_rd_vld;
    logic [1:0] beat_idx;
    logic       fill_we, tag_we, data_we, lru_upd, done;
    logic [2:0] fsm_state, fsm_state_d1;
    logic [3:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;

    int checks = 0;
    int errors = 0;
    int m_hit = 0, m_miss = 0, m_wb = 0;

    typedef struct {
        bit       rd;
        bit       hit;
        bit [0:0] hway;
        bit [0:0] vway;
        bit       dirty;
        int       gap;       // idle cycles before each bus beat
        int       abort_at;  // cycle (accept=1) from which core_en is low; 0=none
    } req_t;

    typedef struct {
        int cycles;  // accept cycle .. last non-IDLE cycle, inclusive
        int done_n;
        int tag_n;
        int data_n;
        int lru_n;
        int fills;
        int wbeats;
        int wreq;    // cycles with bus_wr_req high
        int rreq;    // cycles with bus_rd_req high
        int sel;
    } res_t;

    typedef struct {
        req_t rq;
        res_t ex;
    } vec_t;

    always #5 clk = ~clk;

    l1_cache_ctrl_fsm #(
        .BEATS    (BEATS),
        .NUM_WAYS (2),
        .PERF_W   (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_core_en       (core_en),
        .i_core_req_vld  (core_req_vld),
        .i_core_req_rd   (core_req_rd),
        .o_core_req_rdy  (core_req_rdy),
        .i_tag_hit       (tag_hit),
        .i_hit_way       (hit_way),
        .i_victim_way    (victim_way),
        .i_victim_dirty  (victim_dirty),
        .o_bus_wr_req    (bus_wr_req),
        .i_bus_wr_ack    (bus_wr_ack),
        .o_bus_rd_req    (bus_rd_req),
        .i_bus_rd_vld    (bus_rd_vld),
        .o_beat_idx      (beat_idx),
        .o_sel_way       (sel_way),
        .o_fill_we       (fill_we),
        .o_tag_we        (tag_we),
        .o_data_we       (data_we),
        .o_lru_upd       (lru_upd),
        .o_done          (done),
        .o_fsm_state     (fsm_state),
        .o_fsm_state_d1  (fsm_state_d1),
        .o_perf_hit_cnt  (perf_hit_cnt),
        .o_perf_miss_cnt (perf_miss_cnt),
        .o_perf_wb_cnt   (perf_wb_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= PERF_MAX) ? PERF_MAX : v + 1;
    endfunction

    // Timeline model: each phase occupies a fixed span; an abort lands in one
    // phase and the request ends at the end of that phase with no completion.
    function automatic res_t model(input req_t r);
        res_t e;
        int   per, w, f, c, wb_end, rf_end, end_c;
        e   = '{default: 0};
        per = r.gap + 1;
        w   = (!r.hit && r.dirty) ? BEATS : 0;
        f   = r.hit ? 0 : BEATS;
        c   = (r.hit && r.rd) ? 0 : 1;
        wb_end = 2 + w * per;
        rf_end = wb_end + f * per;
        end_c  = rf_end + c;
        e.sel  = r.hit ? int'(r.hway) : int'(r.vway);
        if (r.abort_at == 0 || r.abort_at > end_c) begin
            e.cycles = end_c;
            e.done_n = 1; e.lru_n = 1;
            e.tag_n  = r.hit ? 0 : 1;
            e.data_n = r.rd ? 0 : 1;
            e.fills  = f; e.wbeats = w; e.wreq = w * per; e.rreq = f * per;
        end else if (r.abort_at <= 2) begin
            e.cycles = 2;
        end else if (r.abort_at <= wb_end) begin
            e.cycles = wb_end; e.wbeats = w; e.wreq = w * per;
        end else if (r.abort_at <= rf_end) begin
            e.cycles = rf_end; e.wbeats = w; e.wreq = w * per;
            e.fills  = f; e.rreq = f * per;
        end else begin
            e.cycles = end_c; e.wbeats = w; e.wreq = w * per;
            e.fills  = f; e.rreq = f * per;
        end
        return e;
    endfunction

    // Drive one request to completion and tally what the DUT did.
    task automatic run_txn(input string nm, input req_t rq, output res_t ob);
        int   cyc = 0, wait_cnt = 0, nfill = 0, nwb = 0;
        bit   ended = 1'b0;
        int   prev_st = 0;
        ob = '{default: 0};
        while (!ended && cyc < 200) begin
            @(negedge clk);
            cyc++;
            core_en      = !(rq.abort_at != 0 && cyc >= rq.abort_at);
            core_req_vld = (cyc == 1);
            core_req_rd  = rq.rd;
            tag_hit      = rq.hit;
            hit_way      = rq.hway;
            victim_way   = rq.vway;
            victim_dirty = rq.dirty;
            // bus responder; strays outside the owning phase must be ignored
            if (bus_wr_req) begin
                bus_wr_ack = (wait_cnt == rq.gap);
                wait_cnt   = bus_wr_ack ? 0 : wait_cnt + 1;
                bus_rd_vld = 1'($urandom_range(0, 1));
            end else if (bus_rd_req) begin
                bus_rd_vld = (wait_cnt == rq.gap);
                wait_cnt   = bus_rd_vld ? 0 : wait_cnt + 1;
                bus_wr_ack = 1'($urandom_range(0, 1));
            end else begin
                bus_wr_ack = 1'($urandom_range(0, 1));
                bus_rd_vld = 1'($urandom_range(0, 1));
            end
            #1;
            if (cyc == 1) begin
                chk({nm, ".rdy"}, int'(core_req_rdy), 1);
                chk({nm, ".start_idle"}, int'(fsm_state), S_IDLE);
            end else begin
                chk({nm, ".state_d1"}, int'(fsm_state_d1), prev_st);
                if (int'(fsm_state) == S_IDLE) begin
                    ended     = 1'b1;
                    ob.cycles = cyc - 1;
                end
            end
            if (!ended) begin
                ob.done_n += int'(done);
                ob.tag_n  += int'(tag_we);
                ob.data_n += int'(data_we);
                ob.lru_n  += int'(lru_upd);
                ob.wreq   += int'(bus_wr_req);
                ob.rreq   += int'(bus_rd_req);
                if (fill_we) begin
                    chk({nm, ".fill_beat"}, int'(beat_idx), nfill);
                    nfill++;
                end
                if (bus_wr_req && bus_wr_ack) begin
                    chk({nm, ".wb_beat"}, int'(beat_idx), nwb);
                    nwb++;
                end
            end
            prev_st = int'(fsm_state);
        end
        if (!ended) begin
            chk({nm, ".timeout"}, 1, 0);
        end
        ob.fills  = nfill;
        ob.wbeats = nwb;
        ob.sel    = int'(sel_way);
        bus_wr_ack = 1'b0;
        bus_rd_vld = 1'b0;
        core_en    = 1'b1;
    endtask

    task automatic run_check(input string nm, input req_t rq, input res_t ex);
        res_t ob;
        run_txn(nm, rq, ob);
        chk({nm, ".cycles"}, ob.cycles, ex.cycles);
        chk({nm, ".done"},   ob.done_n, ex.done_n);
        chk({nm, ".tag_we"}, ob.tag_n,  ex.tag_n);
        chk({nm, ".data_we"}, ob.data_n, ex.data_n);
        chk({nm, ".lru_upd"}, ob.lru_n, ex.lru_n);
        chk({nm, ".fills"},  ob.fills,  ex.fills);
        chk({nm, ".wbeats"}, ob.wbeats, ex.wbeats);
        chk({nm, ".wr_req_cyc"}, ob.wreq, ex.wreq);
        chk({nm, ".rd_req_cyc"}, ob.rreq, ex.rreq);
        chk({nm, ".sel_way"}, ob.sel, ex.sel);
        // lookup always happens, so every request is classified
        if (rq.hit) m_hit = sat(m_hit); else m_miss = sat(m_miss);
        if (!rq.hit && rq.dirty && (rq.abort_at == 0 || rq.abort_at > 2)) m_wb = sat(m_wb);
        chk({nm, ".perf_hit"},  int'(perf_hit_cnt),  PERF_EN ? m_hit  : 0);
        chk({nm, ".perf_miss"}, int'(perf_miss_cnt), PERF_EN ? m_miss : 0);
        chk({nm, ".perf_wb"},   int'(perf_wb_cnt),   PERF_EN ? m_wb   : 0);
    endtask

    initial begin
        vec_t tbl[10];
        req_t rq;
        res_t ex;
        bit   found;

        //             rd   hit  hway vway dirty gap abort   cyc dn tg dt lru fl wb wrq rrq sel
        tbl[0] = '{'{1'b1,1'b1,1'b1,1'b0,1'b0, 0, 0}, '{ 2, 1, 0, 0, 1, 0, 0, 0, 0, 1}};
        tbl[1] = '{'{1'b0,1'b1,1'b0,1'b1,1'b1, 0, 0}, '{ 3, 1, 0, 1, 1, 0, 0, 0, 0, 0}};
        tbl[2] = '{'{1'b1,1'b0,1'b1,1'b0,1'b0, 0, 0}, '{ 7, 1, 1, 0, 1, 4, 0, 0, 4, 0}};
        tbl[3] = '{'{1'b0,1'b0,1'b0,1'b1,1'b1, 2, 0}, '{27, 1, 1, 1, 1, 4, 4,12,12, 1}};
        tbl[4] = '{'{1'b1,1'b0,1'b0,1'b1,1'b1, 0, 0}, '{11, 1, 1, 0, 1, 4, 4, 4, 4, 1}};
        tbl[5] = '{'{1'b1,1'b0,1'b1,1'b0,1'b0, 0, 5}, '{ 6, 0, 0, 0, 0, 4, 0, 0, 4, 0}};
        tbl[6] = '{'{1'b0,1'b0,1'b1,1'b1,1'b1, 0, 2}, '{ 2, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        tbl[7] = '{'{1'b1,1'b0,1'b0,1'b0,1'b1, 0, 6}, '{ 6, 0, 0, 0, 0, 0, 4, 4, 0, 0}};
        tbl[8] = '{'{1'b0,1'b1,1'b1,1'b0,1'b0, 0, 3}, '{ 3, 0, 0, 0, 0, 0, 0, 0, 0, 1}};
        tbl[9] = '{'{1'b0,1'b0,1'b0,1'b1,1'b1, 1, 4}, '{10, 0, 0, 0, 0, 0, 4, 8, 0, 1}};

        rst_n = 1'b0; core_en = 1'b1; core_req_vld = 1'b0; core_req_rd = 1'b0;
        tag_hit = 1'b0; hit_way = 1'b0; victim_way = 1'b0; victim_dirty = 1'b0;
        bus_wr_ack = 1'b0; bus_rd_vld = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst.state", int'(fsm_state), S_IDLE);
        chk("rst.state_d1", int'(fsm_state_d1), S_IDLE);
        chk("rst.beat_idx", int'(beat_idx), 0);
        chk("rst.sel_way", int'(sel_way), 0);
        chk("rst.strobes", int'({bus_wr_req, bus_rd_req, fill_we, tag_we, data_we, lru_upd, done}), 0);
        chk("rst.rdy", int'(core_req_rdy), 1);
        chk("rst.perf", int'({perf_hit_cnt, perf_miss_cnt, perf_wb_cnt}), 0);
        rst_n = 1'b1;

        // request while disabled is not accepted
        @(negedge clk);
        core_en = 1'b0; core_req_vld = 1'b1;
        #1;
        chk("dis.rdy", int'(core_req_rdy), 0);
        @(negedge clk);
        #1;
        chk("dis.state", int'(fsm_state), S_IDLE);
        core_en = 1'b1; core_req_vld = 1'b0;

        // directed table
        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].rq, tbl[i].ex);
        end

        // randomized requests against the timeline model
        for (int i = 0; i < 40; i++) begin
            rq.rd = 1'($urandom_range(0, 1));
            rq.hit = 1'($urandom_range(0, 1));
            rq.hway = 1'($urandom_range(0, 1));
            rq.vway = 1'($urandom_range(0, 1));
            rq.dirty = 1'($urandom_range(0, 1));
            rq.gap = $urandom_range(0, 2);
            rq.abort_at = 0;
            ex = model(rq);
            if ($urandom_range(0, 3) == 0) rq.abort_at = $urandom_range(2, ex.cycles);
            ex = model(rq);
            run_check($sformatf("rnd%0d", i), rq, ex);
        end

        // synchronous reset while on writeback beat 2
        @(negedge clk);
        core_req_vld = 1'b1; core_req_rd = 1'b1; tag_hit = 1'b0;
        victim_dirty = 1'b1; victim_way = 1'b1;
        @(negedge clk);
        core_req_vld = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (int'(fsm_state) == S_WB && beat_idx == 2'd2) found = 1'b1;
            else bus_wr_ack = bus_wr_req;
        end
        chk("rstwb.reached_beat2", int'(found), 1);
        rst_n = 1'b0; bus_wr_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("rstwb.state", int'(fsm_state), S_IDLE);
        chk("rstwb.beat_idx", int'(beat_idx), 0);
        chk("rstwb.bus_wr_req", int'(bus_wr_req), 0);
        chk("rstwb.perf_miss", int'(perf_miss_cnt), 0);
        rst_n = 1'b1; bus_wr_ack = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;

        // 20 read hits saturate the 4-bit hit counter
        rq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        for (int i = 0; i < 20; i++) begin
            run_check($sformatf("sat%0d", i), rq, model(rq));
        end
        chk("sat.perf_hit_final", int'(perf_hit_cnt), PERF_EN ? 15 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
